// File: rtl/alu_mdu_ctrl.sv
// ALU / M-extension execution unit: single-cycle ALU ops plus an iterative
// shift-add multiplier and restoring divider behind a valid/ready handshake.
module alu_mdu_ctrl #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            kill,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            opb5,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_reg, state_next;
    logic                out_valid_reg, out_valid_next;
    logic [XLEN-1:0]     result_reg, result_next;
    logic [SHW-1:0]      cnt_reg, cnt_next;
    logic [XLEN-1:0]     opa_reg, opa_next;      // multiplier / dividend->quotient
    logic [2*XLEN-1:0]   opb_reg, opb_next;      // shifted multiplicand / divisor
    logic [2*XLEN-1:0]   acc_reg, acc_next;      // product / partial remainder
    logic                neg_reg, neg_next;
    logic                rneg_reg, rneg_next;
    logic                hi_reg, hi_next;        // mulh* high half, or rem select

    logic                accept;
    logic                is_m, is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     mag_a, mag_b, alu_res, special_res;
    logic [SHW-1:0]      shamt;
    logic [2*XLEN-1:0]   mul_sum, mul_prod;
    logic [XLEN:0]       div_shift, div_trial;
    logic [XLEN-1:0]     div_rem, div_quo, div_q_fin, div_r_fin;
    logic                last_iter;

    assign in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign busy      = (state_reg != IDLE);
    assign last_iter = (cnt_reg == SHW'(XLEN-1));

    // Operand decode: signedness depends on the M-op flavour.
    always_comb begin
        is_m   = (ALUOp == 2'b10) && opb5 && funct7b0;
        is_div = is_m && funct3[2];
        sgn_a  = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
        sgn_b  = is_div ? !funct3[0] : !funct3[1];
        neg_a  = sgn_a && a[XLEN-1];
        neg_b  = sgn_b && b[XLEN-1];
        mag_a  = neg_a ? -a : a;
        mag_b  = neg_b ? -b : b;
        div_zero = (b == '0);
        div_ovf  = !funct3[0] && (a == MIN_NEG) && (b == '1);
        if (div_zero)
            special_res = funct3[1] ? a : '1;
        else
            special_res = funct3[1] ? '0 : a;
    end

    always_comb begin
        shamt   = b[SHW-1:0];
        alu_res = a + b;
        if (ALUOp == 2'b01) begin
            alu_res = a - b;
        end else if (ALUOp[1]) begin
            case (funct3)
                3'b000:  alu_res = (opb5 && funct7b5) ? a - b : a + b;
                3'b001:  alu_res = a << shamt;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
                3'b011:  alu_res = {{(XLEN-1){1'b0}}, a < b};
                3'b100:  alu_res = a ^ b;
                3'b101:  alu_res = funct7b5 ? $unsigned($signed(a) >>> shamt) : a >> shamt;
                3'b110:  alu_res = a | b;
                default: alu_res = a & b;
            endcase
        end
    end

    // One iteration step of each datapath, evaluated from the current registers.
    always_comb begin
        mul_sum   = acc_reg + (opa_reg[0] ? opb_reg : '0);
        mul_prod  = neg_reg ? -mul_sum : mul_sum;
        div_shift = {acc_reg[XLEN-1:0], opa_reg[XLEN-1]};
        div_trial = div_shift - {1'b0, opb_reg[XLEN-1:0]};
        div_rem   = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
        div_quo   = {opa_reg[XLEN-2:0], ~div_trial[XLEN]};
        div_q_fin = neg_reg ? -div_quo : div_quo;
        div_r_fin = rneg_reg ? -div_rem : div_rem;
    end

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        result_next    = result_reg;
        cnt_next       = cnt_reg;
        opa_next       = opa_reg;
        opb_next       = opb_reg;
        acc_next       = acc_reg;
        neg_next       = neg_reg;
        rneg_next      = rneg_reg;
        hi_next        = hi_reg;

        if (out_valid_reg && out_ready)
            out_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next  = '0;
                    acc_next  = '0;
                    neg_next  = neg_a ^ neg_b;
                    rneg_next = neg_a;
                    if (!is_m) begin
                        result_next    = alu_res;
                        out_valid_next = 1'b1;
                    end else if (is_div && (div_zero || div_ovf)) begin
                        result_next    = special_res;
                        out_valid_next = 1'b1;
                    end else if (is_div) begin
                        state_next = DIV;
                        opa_next   = mag_a;
                        opb_next   = {{XLEN{1'b0}}, mag_b};
                        hi_next    = funct3[1];
                    end else begin
                        state_next = MUL;
                        opa_next   = mag_b;
                        opb_next   = {{XLEN{1'b0}}, mag_a};
                        hi_next    = (funct3[1:0] != 2'b00);
                    end
                end
            end
            MUL: begin
                acc_next = mul_sum;
                opb_next = opb_reg << 1;
                opa_next = opa_reg >> 1;
                cnt_next = cnt_reg + 1'b1;
                if (last_iter) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b1;
                    result_next    = hi_reg ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
                end
            end
            DIV: begin
                acc_next = {{XLEN{1'b0}}, div_rem};
                opa_next = div_quo;
                cnt_next = cnt_reg + 1'b1;
                if (last_iter) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b1;
                    result_next    = hi_reg ? div_r_fin : div_q_fin;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort has priority over everything, including a same-cycle accept.
        if (kill) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            cnt_reg       <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            acc_reg       <= '0;
            neg_reg       <= 1'b0;
            rneg_reg      <= 1'b0;
            hi_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            cnt_reg       <= cnt_next;
            opa_reg       <= opa_next;
            opb_reg       <= opb_next;
            acc_reg       <= acc_next;
            neg_reg       <= neg_next;
            rneg_reg      <= rneg_next;
            hi_reg        <= hi_next;
        end
    end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl (XLEN=32): ALU sweep, MUL/DIV latency and
// corner cases, backpressure, kill and asynchronous reset mid-operation.
module tb_alu_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        kill;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        funct7b0;
    logic        opb5;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_mdu_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kill      (kill),
        .ALUOp     (aluop),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .funct7b0  (funct7b0),
        .opb5      (opb5),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                         input logic f7b0, input logic ob5, input logic [31:0] av,
                         input logic [31:0] bv);
        aluop    = op;
        funct3   = f3;
        funct7b5 = f7b5;
        funct7b0 = f7b0;
        opb5     = ob5;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic f7b5, input logic f7b0, input logic ob5,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic busy_ok;
        issue(op, f3, f7b5, f7b0, ob5, av, bv);
        lat     = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        $display("txn %s: a=%h b=%h result=%h latency=%0d", tag, av, bv, result, lat);
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy/in_ready while iterating"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " busy at result"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic stable;
        logic never_valid;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        kill      = 1'b0;
        out_ready = 1'b1;
        aluop     = 2'b00;
        funct3    = 3'b000;
        funct7b5  = 1'b0;
        funct7b0  = 1'b0;
        opb5      = 1'b0;
        a         = '0;
        b         = '0;

        repeat (2) @(negedge clk);
        $display("txn reset: out_valid=%b result=%h busy=%b in_ready=%b", out_valid, result, busy, in_ready);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // ALU sweep, a=-16, b=4
        run_op("add",   2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4, 1);
        run_op("sub",   2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFEC, 1);
        run_op("sll",   2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FF00, 1);
        run_op("slt",   2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'd1, 1);
        run_op("sltu",  2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'd0, 1);
        run_op("xor",   2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4, 1);
        run_op("srl",   2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'h0FFF_FFFF, 1);
        run_op("sra",   2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF, 1);
        run_op("or",    2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4, 1);
        run_op("and",   2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd4, 32'd0, 1);
        run_op("addi f7b5", 2'b11, 3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4, 1);
        run_op("srai",  2'b11, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1);
        run_op("sll shamt mask", 2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FF00, 1);
        run_op("aluop00 add", 2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 32'd5, 32'd9, 32'd14, 1);
        run_op("aluop01 sub", 2'b01, 3'b111, 1'b0, 1'b1, 1'b1, 32'd5, 32'd9, 32'hFFFF_FFFC, 1);

        // MUL family
        run_op("mulh",   2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu", 2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("mulhu",  2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mul neg", 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33);

        // DIV family
        run_op("div",    2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem",    2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("remu",   2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu by 0", 2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu by 0", 2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd1234, 32'd0, 32'd1234, 1);
        run_op("rem ovf", 2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("div ovf", 2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Backpressure: hold a result for 5 cycles, then drain and accept together
        @(negedge clk);
        out_ready = 1'b0;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
        check("bp first out_valid", {31'd0, out_valid}, 32'd1);
        check("bp first result", result, 32'd3);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || result !== 32'd3 || in_ready) stable = 1'b0;
        end
        $display("txn backpressure hold: result=%h out_valid=%b in_ready=%b", result, out_valid, in_ready);
        check("bp hold stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20);
        $display("txn backpressure release: result=%h out_valid=%b", result, out_valid);
        check("bp back-to-back out_valid", {31'd0, out_valid}, 32'd1);
        check("bp back-to-back result", result, 32'd30);
        @(negedge clk);
        check("bp drained out_valid", {31'd0, out_valid}, 32'd0);

        // kill at cycle 10 of a divu
        issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("kill pre busy", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        $display("txn kill divu: busy=%b in_ready=%b out_valid=%b", busy, in_ready, out_valid);
        check("kill busy", {31'd0, busy}, 32'd0);
        check("kill in_ready", {31'd0, in_ready}, 32'd1);
        check("kill out_valid", {31'd0, out_valid}, 32'd0);
        never_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) never_valid = 1'b0;
        end
        check("kill no late result", {31'd0, never_valid}, 32'd1);
        kill = 1'b1;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        kill = 1'b0;
        $display("txn kill+accept: out_valid=%b", out_valid);
        check("kill wins over accept", {31'd0, out_valid}, 32'd0);
        run_op("add after kill", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 1);

        // asynchronous reset at cycle 20 of a mul
        issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd5, 32'd9);
        repeat (19) @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        $display("txn async reset: result=%h out_valid=%b busy=%b in_ready=%b", result, out_valid, busy, in_ready);
        check("async reset result", result, 32'd0);
        check("async reset out_valid", {31'd0, out_valid}, 32'd0);
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op("mul", 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
- Parametrised successor to the single-cycle ALU control decoder; decodes ALUOp/funct3/funct7 for the full RV32I/RV64I ALU set plus the M extension.
- Executes ALU ops in one registered cycle, and MUL/DIV families on a shared iterative datapath behind a valid/ready handshake.
- Sits between the control unit / register read stage and writeback; the core stalls on in_ready low.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width taken from b[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- kill  in  1  abort the in-flight op and drop any pending result.
- ALUOp  in  2  00 add, 01 sub, 10 R-type, 11 I-type.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instr[30].
- funct7b0  in  1  instr[25]; selects M extension in R-type.
- opb5  in  1  instr[5]; 1 = R-type opcode.
- a, b  in  XLEN  operands (b = immediate for I-type).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (async, reset_n low): state=IDLE, out_valid=0, result=0, busy=0, all iteration registers 0. in_ready is 1 after reset.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Decode, ALUOp 00: add. ALUOp 01: sub.
- Decode, ALUOp 1x with ALU ops by funct3:
  - 000: sub when opb5 && funct7b5, else add.
  - 001 sll; 010 slt (signed); 011 sltu; 100 xor.
  - 101: sra when funct7b5, else srl. funct7b5 honoured for I-type too.
  - 110 or; 111 and.
- Decode, M op: ALUOp==10 && opb5 && funct7b0.
  - funct3 0xx: MUL family (000 mul low, 001 mulh, 010 mulhsu, 011 mulhu).
  - funct3 1xx: DIV family (100 div, 101 divu, 110 rem, 111 remu).
- ALU op latency: result registered, out_valid=1 the cycle after accept.
- MUL, states IDLE -> MUL -> IDLE:
  - Operands converted to magnitudes per signedness.
  - XLEN shift-add iterations, one per cycle; counter counts 0..XLEN-1.
  - 2*XLEN product negated if the sign flag is set. mul returns the low half; mulh* return the high half.
  - out_valid asserts XLEN+1 cycles after accept. busy=1 while in MUL.
- DIV, states IDLE -> DIV -> IDLE:
  - Restoring division on magnitudes, XLEN iterations.
  - Quotient sign = sign(a) ^ sign(b); remainder sign = sign(a), for signed ops only.
  - Latency XLEN+1.
  - b==0: quotient all ones, remainder = a, latency 1, no iteration.
  - Signed overflow (a = most-negative, b = -1): quotient = a, remainder 0, latency 1.
- Output hold: out_valid and result hold until out_ready. A new accept in the same cycle as out_ready is legal (back-to-back ALU ops at one per cycle).
- kill:
  - Forces state=IDLE, busy=0, out_valid=0 next edge.
  - kill with simultaneous accept: kill wins, request is dropped.
- No new request is accepted while busy; in_valid is ignored (in_ready=0).
- Async reset mid-iteration: immediately returns to IDLE; partial results are discarded.
- All arithmetic is modulo 2^XLEN. Shift amount is b[SHW-1:0] only; upper bits are ignored.

Test Plan (XLEN=32):
- ALU sweep: ALUOp=10, opb5=1, a=0xFFFF_FFF0, b=4, each funct3 and funct7b5 combination. Expected: sub=0xFFFF_FFEC, sra=0xFFFF_FFFF, srl=0x0FFF_FFFF, sltu=0, slt=1. Each has out_valid one cycle after accept. Then ALUOp=11 with funct7b5=1, funct3=000: expect add (no sub).
- mulh: a=0x8000_0000, b=0x8000_0000 -> result 0x4000_0000, out_valid exactly 33 cycles after accept, busy high cycles 1..32, in_ready low throughout. Then mulhsu with a=-1, b=2 -> 0xFFFF_FFFF.
- div: a=-7, b=2 -> 0xFFFF_FFFD; rem -> 0xFFFF_FFFF. Then divu with b=0 -> 0xFFFF_FFFF at latency 1; rem a=0x8000_0000, b=-1 -> 0 at latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a result. Expect result and out_valid stable and in_ready=0. Then out_ready=1 with in_valid=1 (add) -> both complete back-to-back.
- kill at cycle 10 of a divu -> busy=0 and in_ready=1 next cycle, no out_valid; the following add 3+4 returns 7.
- Drop reset_n at cycle 20 of a mul -> outputs 0 immediately; after release, mul 6*7 -> 42.
